// File: rtl/uart_rx_bit_sampler.sv
// Oversampling front end of the UART receiver: synchronizer, bit timing, mid-bit sampling.
// UART_RX_MAJORITY_VOTE_EN selects a three-sample majority vote; undefined keeps one mid sample.
module uart_rx_bit_sampler #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  cnt_en,
    input  logic                  smp_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  sampled_bit,
    output logic                  sample_done
);

    localparam logic [PRESCALE_W-1:0] P8   = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] P16  = PRESCALE_W'(16);
    localparam logic [PRESCALE_W-1:0] P32  = PRESCALE_W'(32);
    localparam logic [PRESCALE_W-1:0] ONE  = PRESCALE_W'(1);
    localparam logic [BIT_CNT_W-1:0]  BONE = BIT_CNT_W'(1);

    logic                  sync_q1;
    logic                  rx_sync;
    logic                  s1;
    logic                  vote;
    logic [PRESCALE_W-1:0] p_eff;
    logic [PRESCALE_W-1:0] p_last;
    logic [PRESCALE_W-1:0] mid;
    logic                  at_wrap;
    logic                  at_m0;
    logic                  at_m1;
    logic                  at_m2;
    logic                  smp_on;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1 <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            sync_q1 <= rx_in;
            rx_sync <= sync_q1;
        end
    end

    // Anything other than 16 or 32 runs at 8x.
    always_comb begin
        p_eff = P8;
        unique case (1'b1)
            (prescale == P16): p_eff = P16;
            (prescale == P32): p_eff = P32;
            default:           p_eff = P8;
        endcase
    end

    always_comb begin
        p_last  = p_eff - ONE;
        mid     = p_eff >> 1;
        at_wrap = (edge_cnt >= p_last);
        at_m0   = (edge_cnt == mid - ONE);
        at_m1   = (edge_cnt == mid);
        at_m2   = (edge_cnt == mid + ONE);
        smp_on  = cnt_en & smp_en;
    end

    // >= rather than == so a prescale shrink mid-frame still wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!cnt_en) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (at_wrap) begin
            edge_cnt <= '0;
            if (bit_cnt != '1) begin
                bit_cnt <= bit_cnt + BONE;
            end
        end else begin
            edge_cnt <= edge_cnt + ONE;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic s0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0 <= 1'b1;
        end else if (smp_on && at_m0) begin
            s0 <= rx_sync;
        end
    end

    assign vote = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);
`else
    assign vote = s1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1          <= 1'b1;
            sampled_bit <= 1'b1;
            sample_done <= 1'b0;
        end else begin
            sample_done <= 1'b0;
            if (smp_on && at_m1) begin
                s1 <= rx_sync;
            end
            if (smp_on && at_m2) begin
                sampled_bit <= vote;
                sample_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// Scoreboard bench for uart_rx_bit_sampler: directed scenarios plus random frames
// checked against a per-edge behavioural model of bit timing and mid-bit voting.
`timescale 1ns/1ps
module tb_uart_rx_bit_sampler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       cnt_en = 1'b0;
    logic       smp_en = 1'b0;
    logic [5:0] prescale = 6'd8;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       sampled_bit;
    logic       sample_done;

    uart_rx_bit_sampler #(
        .PRESCALE_W(6),
        .BIT_CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_in(rx_in),
        .prescale(prescale),
        .cnt_en(cnt_en),
        .smp_en(smp_en),
        .edge_cnt(edge_cnt),
        .bit_cnt(bit_cnt),
        .sampled_bit(sampled_bit),
        .sample_done(sample_done)
    );

    always #5 clk = ~clk;

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam bit VOTE = 1'b1;
`else
    localparam bit VOTE = 1'b0;
`endif

    typedef struct packed {
        logic [5:0] e;
        logic [3:0] b;
        logic       d;
        logic       s;
    } cyc_t;

    cyc_t       cyc_q[$];
    logic [4:0] done_q[$];
    int         log_v[$];
    int         log_e[$];
    int         log_b[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Model: length of the current enabled run and the line history per edge.
    int         run_len = 0;
    logic       m_sbit  = 1'b1;
    logic [4:0] hist    = 5'b11111;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff_p(input int ps);
        return (ps == 8 || ps == 16 || ps == 32) ? ps : 8;
    endfunction

    task automatic step(input logic rx, input logic en, input logic se,
                        input int ps);
        int   p;
        int   m;
        int   pe;
        int   ones;
        int   bc;
        logic done;
        cyc_t c;
        @(negedge clk);
        rst      = 1'b1;
        rx_in    = rx;
        cnt_en   = en;
        smp_en   = se;
        prescale = 6'(ps);
        p    = eff_p(ps);
        m    = p / 2;
        hist = {hist[3:0], rx};
        done = 1'b0;
        if (!en) begin
            run_len = 0;
        end else begin
            pe = run_len % p;
            run_len++;
            if (se && pe == m + 1) begin
                done = 1'b1;
                ones = int'(hist[4]) + int'(hist[3]) + int'(hist[2]);
                m_sbit = VOTE ? (ones >= 2) : hist[3];
            end
        end
        bc  = run_len / p;
        c.e = 6'(run_len % p);
        c.b = 4'(bc > 15 ? 15 : bc);
        c.d = done;
        c.s = m_sbit;
        cyc_q.push_back(c);
        if (done) done_q.push_back({c.b, m_sbit});
    endtask

    task automatic idle(input int n, input int ps);
        for (int i = 0; i < n; i++) begin
            step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), ps);
        end
    endtask

    task automatic do_reset();
        cyc_t c;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_edge_cnt", 32'(edge_cnt), 0);
        check("rst_bit_cnt", 32'(bit_cnt), 0);
        check("rst_sampled_bit", 32'(sampled_bit), 1);
        check("rst_sample_done", 32'(sample_done), 0);
        run_len = 0;
        m_sbit  = 1'b1;
        hist    = 5'b11111;
        c = '{e: 6'd0, b: 4'd0, d: 1'b0, s: 1'b1};
        cyc_q.push_back(c);
    endtask

    task automatic clear_log();
        log_v.delete();
        log_e.delete();
        log_b.delete();
    endtask

    always @(posedge clk) begin
        cyc_t       c;
        logic [4:0] d;
        #2;
        if (cyc_q.size() > 0) begin
            c = cyc_q.pop_front();
            check("edge_cnt", 32'(edge_cnt), 32'(c.e));
            check("bit_cnt", 32'(bit_cnt), 32'(c.b));
            check("sample_done", 32'(sample_done), 32'(c.d));
            check("sampled_bit", 32'(sampled_bit), 32'(c.s));
        end
        if (sample_done === 1'b1) begin
            log_v.push_back(int'(sampled_bit));
            log_e.push_back(int'(edge_cnt));
            log_b.push_back(int'(bit_cnt));
            check("done_expected", 32'(done_q.size() > 0), 1);
            if (done_q.size() > 0) begin
                d = done_q.pop_front();
                check("done_value", 32'(sampled_bit), 32'(d[0]));
                check("done_bit_cnt", 32'(bit_cnt), 32'(d[4:1]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;
        int         idx;
        #1 rst = 1'b0;
        #1;
        check("init_edge_cnt", 32'(edge_cnt), 0);
        check("init_bit_cnt", 32'(bit_cnt), 0);
        check("init_sampled_bit", 32'(sampled_bit), 1);
        check("init_sample_done", 32'(sample_done), 0);
        repeat (2) @(negedge clk);

        // Basic frame 0,1,0,1 at 8x, line shifted two clocks ahead.
        pat = 4'b1010;
        idle(4, 8);
        clear_log();
        for (int i = 0; i < 32; i++) begin
            idx = (i + 2) / 8;
            if (idx > 3) idx = 3;
            step(pat[idx], 1'b1, 1'b1, 8);
        end
        idle(3, 8);
        check("basic_count", 32'(log_v.size()), 4);
        for (int j = 0; j < 4; j++) begin
            if (j < log_v.size()) begin
                check("basic_bit", 32'(log_v[j]), 32'(pat[j]));
                check("basic_edge", 32'(log_e[j]), 6);
                check("basic_bitcnt", 32'(log_b[j]), 32'(j));
            end
        end

        // Glitch on the middle sample of a 16x bit of value 1.
        idle(4, 16);
        clear_log();
        for (int i = 0; i < 16; i++) begin
            step((i == 6) ? 1'b0 : 1'b1, 1'b1, 1'b1, 16);
        end
        idle(3, 16);
        check("glitch_count", 32'(log_v.size()), 1);
        if (log_v.size() > 0) begin
            check("glitch_bit", 32'(log_v[0]), VOTE ? 32'd1 : 32'd0);
        end

        // Illegal prescale falls back to 8x.
        idle(3, 10);
        clear_log();
        for (int i = 0; i < 20; i++) begin
            step(1'($urandom_range(0, 1)), 1'b1, 1'b1, 10);
        end
        idle(3, 10);
        check("illegal_count", 32'(log_v.size()), 2);
        if (log_e.size() > 0) check("illegal_edge", 32'(log_e[0]), 6);

        // Enable gating: drop cnt_en at edge 3, then a full bit without smp_en.
        idle(3, 8);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8);
        step(1'b0, 1'b0, 1'b1, 8);
        clear_log();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8);
        idle(3, 8);
        check("gate_no_done", 32'(log_v.size()), 0);

        // Asynchronous reset with edge_cnt at 5.
        idle(3, 8);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 8);
        do_reset();
        idle(3, 8);

        // Saturation of bit_cnt over 20 bits at 32x.
        for (int i = 0; i < 20 * 32 + 8; i++) begin
            step(1'($urandom_range(0, 1)), 1'b1, 1'b1, 32);
        end
        idle(3, 32);

        // Random frames: prescale fixed per frame, smp_en changes only at bit starts.
        for (int f = 0; f < 40; f++) begin
            int         ps;
            int         p;
            int         len;
            logic       se;
            logic       rxv;
            logic [7:0] fb;
            case ($urandom_range(0, 3))
                0:       ps = 8;
                1:       ps = 16;
                2:       ps = 32;
                default: ps = int'($urandom_range(0, 63));
            endcase
            p   = eff_p(ps);
            fb  = 8'($urandom);
            se  = 1'b1;
            idle(int'($urandom_range(1, 3)), ps);
            len = int'($urandom_range(1, 6 * p));
            for (int i = 0; i < len; i++) begin
                if (i % p == 0) se = ($urandom_range(0, 3) != 0);
                rxv = fb[(i + 2) / p] ^ ($urandom_range(0, 9) == 0);
                step(rxv, 1'b1, se, ps);
            end
        end

        idle(3, 8);
        repeat (3) @(negedge clk);
        check("cyc_q_drained", 32'(cyc_q.size()), 0);
        check("done_q_drained", 32'(done_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_bit_sampler.md
# uart_rx_bit_sampler

Oversampling front end of the UART receiver. It synchronizes the serial `rx_in` line and runs the edge and bit counters that time each bit. It takes three mid-bit samples and majority-votes them into `sampled_bit`, with a one-cycle `sample_done` strobe. It sits between the RX pin and the RX FSM; the parity, start and stop check stages consume its `sampled_bit` output.

## Interface
- `PRESCALE_W`, default 6: width of `prescale` and `edge_cnt`.
- `BIT_CNT_W`, default 4: width of `bit_cnt`.
- `clk` input, 1 bit: receiver oversampling clock.
- `rst` input, 1 bit: reset, asynchronous, active-low.
- `rx_in` input, 1 bit: asynchronous serial line, idle high.
- `prescale` input, `PRESCALE_W` bits: oversampling ratio. Legal values are 8, 16 and 32; any other value is treated as 8.
- `cnt_en` input, 1 bit: counter enable from the RX FSM. Low clears the counters.
- `smp_en` input, 1 bit: sampling enable from the RX FSM.
- `edge_cnt` output, `PRESCALE_W` bits: oversample tick index within the current bit.
- `bit_cnt` output, `BIT_CNT_W` bits: index of the bit within the frame.
- `sampled_bit` output, 1 bit: decided value of the current bit.
- `sample_done` output, 1 bit: one-cycle pulse on the cycle `sampled_bit` is updated.

## Operation
- **Synchronizer:** two-flop synchronizer on `rx_in` produces `rx_sync`. Both flops reset to 1.
- **Effective prescale:** `P` = `prescale` when it is 8, 16 or 32, otherwise 8. The mid point is `M` = `P/2`.
- **Edge counter, `cnt_en` high:**
  - `edge_cnt` increments each clk.
  - When `edge_cnt >= P-1`, it wraps to 0 and `bit_cnt` increments.
  - The `>=` compare covers a `prescale` change mid-frame, which is illegal but must not hang.
  - `bit_cnt` saturates at all-ones.
- **Edge counter, `cnt_en` low:** `edge_cnt` and `bit_cnt` clear to 0 at the next edge. `sample_done` is 0. `sampled_bit` holds.
- **Sample capture, `cnt_en` and `smp_en` both high:**
  - At the edge where `edge_cnt == M-1`, `s0 <= rx_sync`.
  - At the edge where `edge_cnt == M`, `s1 <= rx_sync`.
  - At the edge where `edge_cnt == M+1`, `sampled_bit <= maj(s0, s1, rx_sync)` and `sample_done <= 1`.
  - `maj(a,b,c)` = `ab | ac | bc`.
- **`smp_en` low:** no capture into `s0`/`s1`, no `sampled_bit` update and no `sample_done`. The counters still run.
- **`sample_done`:** exactly one cycle high per bit, never two consecutive cycles.
- **Reset values:**
  - `edge_cnt` = 0, `bit_cnt` = 0.
  - `sampled_bit` = 1, `s0` = `s1` = 1.
  - `sample_done` = 0.
  - Synchronizer flops = 1.
- **Reset mid-frame:** all state returns to the reset values immediately, since reset is asynchronous. Operation resumes on the first edge after `rst` deasserts, with `cnt_en` sampled normally.

## Timing
- `rx_in` reaches `rx_sync` after 2 clk.
- `sampled_bit` and `sample_done` become visible in the cycle where `edge_cnt == M+2`. With `P` = 8 that is `edge_cnt == 6`.
- One bit period is exactly `P` clk. `bit_cnt` changes in the cycle `edge_cnt` shows 0.
- The first cycle after `cnt_en` rises shows `edge_cnt == 0` and `bit_cnt == 0`. Counting starts on the following edge.
- Outputs are fully registered, with no combinational path from `rx_in`.

## Configuration
- **Macro:** `UART_RX_MAJORITY_VOTE_EN`.
- **Defined:** three-sample majority vote as described in Operation.
- **Undefined:**
  - The `s0` register is removed.
  - `sampled_bit <= s1` at the `M+1` edge, i.e. the single sample captured at `M`.
  - `sample_done`, latency and all other timing are identical to the defined case.

## Test plan
- **Reset:** assert `rst` low mid-count with `edge_cnt` = 5. Required: `edge_cnt` = 0, `bit_cnt` = 0, `sampled_bit` = 1 and `sample_done` = 0 immediately, without waiting for a clk edge.
- **Basic frame:** `prescale` = 8, `cnt_en` = `smp_en` = 1, `rx_in` stream 0,1,0,1 bits, each held 8 clk and aligned for the 2-clk synchronizer. Required:
  - `sample_done` pulses once per bit, when `edge_cnt` = 6.
  - `sampled_bit` follows the sequence 0,1,0,1.
  - `bit_cnt` steps 0 to 3.
- **Glitch rejection:** `prescale` = 16, bit = 1, with `rx_sync` forced 0 for one clk, the cycle `edge_cnt == 8`. Required:
  - With the macro defined, `sampled_bit` = 1.
  - With it undefined, `sampled_bit` = 0.
- **Illegal prescale:** `prescale` = 10. Required: `edge_cnt` wraps after 7, bit period is 8 clk, and sampling happens at `M` = 4.
- **Enable gating:** drop `cnt_en` at `edge_cnt` = 3. Required: `edge_cnt` = 0 next cycle, `bit_cnt` = 0, `sampled_bit` unchanged. Hold `smp_en` = 0 for a full bit; required: no `sample_done`.
- **Saturation:** `cnt_en` held for 20 bit periods at `prescale` = 32. Required: `bit_cnt` stops at 15 and `edge_cnt` continues wrapping 0 to 31.
